coherence_bus_ctrl: RTL and testbench

//  N-core MSI snooping bus controller between per-core L1 I/D caches and one shared RAM port.

---
 rtl/coherence_bus_ctrl_pkg.sv | 9 +
 rtl/coherence_bus_ctrl_if.sv | 21 ++
 rtl/coherence_bus_ctrl_rr_arbiter.sv | 25 ++
 rtl/coherence_bus_ctrl.sv | 145 ++++++++++++++
 tb/tb_coherence_bus_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/coherence_bus_ctrl_pkg.sv
// coherence_bus_ctrl_pkg: shared word, RAM-state and controller-state types for the MSI bus controller
package coherence_bus_ctrl_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [3:0] {IDLE, SNP1, SNP2, LD, FWD, FWDWB, WB, GAP, INV1, INV2, IRD} coh_state_t;
  function automatic int word_idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/coherence_bus_ctrl_if.sv
// coherence_bus_ctrl_if: cache, snoop, RAM and statistics signals between cores, RAM and the bus controller
interface coherence_bus_ctrl_if
  import coherence_bus_ctrl_pkg::*;
#(parameter int NCORES = 2, parameter int CNT_W = 32);
  logic [NCORES-1:0] iREN, iwait, dREN, dWEN, dwait, cctrans, ccwrite, ccwait, ccinv;
  word_t [NCORES-1:0] iaddr, iload, daddr, dstore, dload, ccsnoopaddr;
  logic ramREN, ramWEN;
  word_t ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  logic [CNT_W-1:0] stat_c2c, stat_memrd, stat_memwr, stat_inv;
  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    output iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore,
           stat_c2c, stat_memrd, stat_memwr, stat_inv
  );
  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, cctrans, ccwrite, ramload, ramstate,
    input  iwait, iload, dwait, dload, ccwait, ccinv, ccsnoopaddr, ramREN, ramWEN, ramaddr, ramstore,
           stat_c2c, stat_memrd, stat_memwr, stat_inv
  );
endinterface

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// rr_arbiter: grants the first request at or after ptr, wrapping around the N requesters
module rr_arbiter
  import coherence_bus_ctrl_pkg::*;
#(parameter int N = 2, parameter int IW = word_idx_w(N)) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o
);
  int idx;
  // scan farthest to nearest so the closest request to ptr is written last
  always_comb begin
    grant_o = '0;
    grant_idx_o = '0;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (req_i[idx]) begin
        grant_o = '0;
        grant_o[idx] = 1'b1;
        grant_idx_o = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/coherence_bus_ctrl.sv
// coherence_bus_ctrl: round-robin MSI snooping bus controller for NCORES cores sharing one RAM port.
// Define COH_STATS_EN to build saturating transaction counters; otherwise the stat outputs read 0.
module coherence_bus_ctrl
  import coherence_bus_ctrl_pkg::*;
#(parameter int NCORES = 2, parameter int BLOCK_WORDS = 2) (
  input logic CLK,
  input logic RST,
  coherence_bus_ctrl_if.master bus
);
  localparam int IW = word_idx_w(NCORES);
  localparam int WW = word_idx_w(BLOCK_WORDS);
  coh_state_t state_q, ret_q;
  logic [IW-1:0] ptr_q, owner_q, resp_q, gidx, rsp_idx;
  logic [WW-1:0] word_q;
  logic [NCORES-1:0] owner_oh_q, grant, req, rsp;
  word_t daddr_q, iaddr_q;
  logic ccwrite_q, acc, adv, last, snooping;
  assign req = bus.cctrans | bus.iREN;
  assign rsp = bus.cctrans & ~owner_oh_q;
  assign acc = bus.ramstate == ACCESS;
  assign adv = acc || state_q == FWD;
  assign last = word_q == WW'(BLOCK_WORDS - 1);
  assign snooping = state_q inside {SNP1, SNP2, LD, FWD, FWDWB} || (state_q == GAP && ret_q != WB);
  rr_arbiter #(.N(NCORES), .IW(IW)) u_arb (.req_i(req), .ptr_i(ptr_q), .grant_o(grant), .grant_idx_o(gidx));
  always_comb begin
    rsp_idx = '0;
    for (int k = NCORES - 1; k >= 0; k--) if (rsp[k]) rsp_idx = IW'(k);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      ret_q <= IDLE;
      ptr_q <= '0;
      owner_q <= '0;
      owner_oh_q <= '0;
      resp_q <= '0;
      word_q <= '0;
      daddr_q <= '0;
      iaddr_q <= '0;
      ccwrite_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|req) begin
          owner_q <= gidx;
          owner_oh_q <= grant;
          ptr_q <= gidx == IW'(NCORES - 1) ? '0 : gidx + 1'b1;
          daddr_q <= bus.daddr[gidx];
          iaddr_q <= bus.iaddr[gidx];
          ccwrite_q <= bus.ccwrite[gidx];
          word_q <= '0;
          state_q <= !bus.cctrans[gidx] ? IRD : bus.dREN[gidx] ? SNP1 : bus.dWEN[gidx] ? WB : INV1;
        end
        SNP1: state_q <= SNP2;
        SNP2: begin
          resp_q <= rsp_idx;
          state_q <= ~|rsp ? LD : ccwrite_q ? FWD : FWDWB;
        end
        LD, FWD, FWDWB, WB: if (adv) begin
          word_q <= word_q + 1'b1;
          ret_q <= state_q;
          state_q <= !last ? GAP : (state_q == WB || !ccwrite_q) ? IDLE : INV1;
        end
        GAP: state_q <= ret_q;
        INV1: state_q <= INV2;
        INV2: state_q <= IDLE;
        IRD: if (acc) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  always_comb begin
    bus.iwait = '1;
    bus.dwait = '1;
    bus.iload = '0;
    bus.dload = '0;
    bus.ccinv = '0;
    bus.ramREN = 1'b0;
    bus.ramWEN = 1'b0;
    bus.ramaddr = '0;
    bus.ramstore = '0;
    bus.ccwait = snooping ? ~owner_oh_q : '0;
    for (int j = 0; j < NCORES; j++) bus.ccsnoopaddr[j] = owner_oh_q[j] ? '0 : daddr_q;
    case (state_q)
      LD: begin
        bus.ramREN = 1'b1;
        bus.ramaddr = bus.daddr[owner_q];
        bus.dload[owner_q] = bus.ramload;
        bus.dwait[owner_q] = !acc;
      end
      FWD: begin
        bus.dload[owner_q] = bus.dstore[resp_q];
        bus.dwait[owner_q] = 1'b0;
        bus.dwait[resp_q] = 1'b0;
      end
      FWDWB: begin
        bus.ramWEN = 1'b1;
        bus.ramaddr = bus.daddr[resp_q];
        bus.ramstore = bus.dstore[resp_q];
        bus.dload[owner_q] = bus.dstore[resp_q];
        bus.dwait[owner_q] = !acc;
        bus.dwait[resp_q] = !acc;
      end
      WB: begin
        bus.ramWEN = 1'b1;
        bus.ramaddr = bus.daddr[owner_q];
        bus.ramstore = bus.dstore[owner_q];
        bus.dwait[owner_q] = !acc;
      end
      INV1: bus.ccinv = ~owner_oh_q;
      INV2: bus.dwait[owner_q] = 1'b0;
      IRD: begin
        bus.ramREN = 1'b1;
        bus.ramaddr = iaddr_q;
        bus.iload[owner_q] = bus.ramload;
        bus.iwait[owner_q] = !acc;
      end
      default: ;
    endcase
  end
`ifdef COH_STATS_EN
  logic fin, inc_c2c, inc_rd, inc_wr;
  assign fin = state_q inside {LD, FWD, FWDWB, WB} && adv && last;
  assign inc_c2c = fin && state_q inside {FWD, FWDWB};
  assign inc_rd = (fin && state_q == LD) || (state_q == IRD && acc);
  assign inc_wr = fin && state_q inside {WB, FWDWB};
  always_ff @(posedge CLK) begin
    if (RST) begin
      bus.stat_c2c <= '0;
      bus.stat_memrd <= '0;
      bus.stat_memwr <= '0;
      bus.stat_inv <= '0;
    end else begin
      if (inc_c2c && !(&bus.stat_c2c)) bus.stat_c2c <= bus.stat_c2c + 1'b1;
      if (inc_rd && !(&bus.stat_memrd)) bus.stat_memrd <= bus.stat_memrd + 1'b1;
      if (inc_wr && !(&bus.stat_memwr)) bus.stat_memwr <= bus.stat_memwr + 1'b1;
      if (state_q == INV1 && !(&bus.stat_inv)) bus.stat_inv <= bus.stat_inv + 1'b1;
    end
  end
`else
  assign bus.stat_c2c = '0;
  assign bus.stat_memrd = '0;
  assign bus.stat_memwr = '0;
  assign bus.stat_inv = '0;
`endif
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// tb_coherence_bus_ctrl: directed checks of arbitration, snoop fills, forwarding, writeback, invalidate and reset
module tb_coherence_bus_ctrl;
  import coherence_bus_ctrl_pkg::*;
  localparam int N = 4;
`ifdef COH_STATS_EN
  localparam logic [31:0] ST = 32'd1;
`else
  localparam logic [31:0] ST = 32'd0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  int n_chk = 0, n_fail = 0;
  coherence_bus_ctrl_if #(.NCORES(N), .CNT_W(32)) bus ();
  coherence_bus_ctrl #(.NCORES(N), .BLOCK_WORDS(2)) dut (.CLK(clk), .RST(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wb_word(input word_t d, input word_t a);
    bus.dstore[0] = d;
    bus.daddr[0] = a;
    for (int i = 0; i < 3; i++) begin
      bus.ramstate = BUSY;
      #2;
      chk("e_busy_wen", bus.ramWEN, 1);
      chk("e_busy_dwait", bus.dwait, 4'hF);
      tick();
    end
    bus.ramstate = ACCESS;
    #2;
    chk("e_store", bus.ramstore, d);
    chk("e_addr", bus.ramaddr, a);
    chk("e_dwait", bus.dwait, 4'b1110);
    bus.dWEN = '0;
    bus.cctrans = '0;
    tick();
    bus.ramstate = FREE;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0; bus.cctrans = '0; bus.ccwrite = '0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = FREE;
    tick();
    rst = 1'b0;
    #2;
    chk("rst_iwait", bus.iwait, 4'hF);
    chk("rst_dwait", bus.dwait, 4'hF);
    chk("rst_ram", {bus.ramREN, bus.ramWEN}, 0);
    chk("rst_ccwait", bus.ccwait, 0);
    chk("rst_stat", bus.stat_c2c, 0);
    // core2 read miss, nobody responds: two snoop cycles then two RAM words
    bus.dREN[2] = 1'b1; bus.cctrans[2] = 1'b1; bus.daddr[2] = 32'h100;
    #2; chk("a_idle_ren", bus.ramREN, 0);
    tick(); #2;
    chk("a_snp1_ccwait", bus.ccwait, 4'b1011);
    chk("a_snoopaddr", bus.ccsnoopaddr[0], 32'h100);
    chk("a_snp1_ram", {bus.ramREN, bus.ramWEN}, 0);
    tick(); #2;
    chk("a_snp2_ccwait", bus.ccwait, 4'b1011);
    chk("a_snp2_ram", bus.ramREN, 0);
    tick(); bus.ramstate = BUSY; #2;
    chk("a_ld0_ren", bus.ramREN, 1);
    chk("a_ld0_addr", bus.ramaddr, 32'h100);
    chk("a_ld0_busy", bus.dwait, 4'hF);
    tick(); bus.ramstate = ACCESS; bus.ramload = 32'hA0; #2;
    chk("a_ld0_dwait", bus.dwait, 4'b1011);
    chk("a_ld0_dload", bus.dload[2], 32'hA0);
    tick(); bus.ramstate = FREE; bus.daddr[2] = 32'h104; #2;
    chk("a_gap_ren", bus.ramREN, 0);
    chk("a_gap_dwait", bus.dwait, 4'hF);
    tick(); bus.ramstate = ACCESS; bus.ramload = 32'hA1; bus.dREN = '0; bus.cctrans = '0; #2;
    chk("a_ld1_addr", bus.ramaddr, 32'h104);
    chk("a_ld1_dload", bus.dload[2], 32'hA1);
    chk("a_ld1_dwait", bus.dwait, 4'b1011);
    tick(); bus.ramstate = FREE; #2;
    chk("a_idle_ren2", bus.ramREN, 0);
    chk("a_idle_ccwait", bus.ccwait, 0);
    chk("a_memrd", bus.stat_memrd, ST);
    // core0 icache fill moves ptr to 1
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h200;
    tick(); bus.ramstate = BUSY; bus.iREN = '0; #2;
    chk("i_ren", bus.ramREN, 1);
    chk("i_addr", bus.ramaddr, 32'h200);
    chk("i_busy", bus.iwait, 4'hF);
    tick(); bus.ramstate = ACCESS; bus.ramload = 32'h55; #2;
    chk("i_iwait", bus.iwait, 4'b1110);
    chk("i_iload", bus.iload[0], 32'h55);
    tick(); bus.ramstate = FREE;
    // cores 0,1,3 invalidate together with ptr=1: served 1, 3, 0
    bus.cctrans = 4'b1011;
    tick(); #2;
    chk("b_inv_c1", bus.ccinv, 4'b1101);
    chk("b_inv1_dwait", bus.dwait, 4'hF);
    tick(); bus.cctrans[1] = 1'b0; #2;
    chk("b_inv2_c1", bus.dwait, 4'b1101);
    chk("b_inv2_ccinv", bus.ccinv, 0);
    tick();
    tick(); #2; chk("b_inv_c3", bus.ccinv, 4'b0111);
    tick(); bus.cctrans[3] = 1'b0; #2; chk("b_inv2_c3", bus.dwait, 4'b0111);
    tick();
    tick(); #2; chk("b_inv_c0", bus.ccinv, 4'b1110);
    tick(); bus.cctrans[0] = 1'b0; #2; chk("b_inv2_c0", bus.dwait, 4'b1110);
    chk("b_stat_inv", bus.stat_inv, ST * 3);
    tick();
    // core0 read, core3 holds the line modified: forward with writeback
    bus.cctrans[0] = 1'b1; bus.dREN[0] = 1'b1; bus.daddr[0] = 32'h300;
    tick(); #2; chk("c_snp1_ccwait", bus.ccwait, 4'b1110);
    tick(); bus.cctrans[3] = 1'b1; bus.dstore[3] = 32'hC0; bus.daddr[3] = 32'h300; #2;
    chk("c_snp2_ccwait", bus.ccwait, 4'b1110);
    tick(); bus.ramstate = BUSY; #2;
    chk("c_w0_wen", {bus.ramREN, bus.ramWEN}, 2'b01);
    chk("c_w0_store", bus.ramstore, 32'hC0);
    chk("c_w0_addr", bus.ramaddr, 32'h300);
    chk("c_w0_busy", bus.dwait, 4'hF);
    chk("c_w0_dload", bus.dload[0], 32'hC0);
    tick(); bus.ramstate = ACCESS; #2;
    chk("c_w0_dwait", bus.dwait, 4'b0110);
    tick(); bus.ramstate = FREE; bus.dstore[3] = 32'hC1; bus.daddr[3] = 32'h304; #2;
    chk("c_gap_wen", bus.ramWEN, 0);
    chk("c_gap_dwait", bus.dwait, 4'hF);
    tick(); bus.ramstate = ACCESS; bus.cctrans = '0; bus.dREN = '0; #2;
    chk("c_w1_store", bus.ramstore, 32'hC1);
    chk("c_w1_addr", bus.ramaddr, 32'h304);
    chk("c_w1_dload", bus.dload[0], 32'hC1);
    chk("c_w1_dwait", bus.dwait, 4'b0110);
    tick(); bus.ramstate = FREE; #2;
    chk("c_idle_wen", bus.ramWEN, 0);
    chk("c_stat_c2c", bus.stat_c2c, ST);
    chk("c_stat_memwr", bus.stat_memwr, ST);
    // core1 write miss against core0 iREN (ptr=1 picks core1); core0 supplies, then invalidate
    bus.dREN[1] = 1'b1; bus.cctrans[1] = 1'b1; bus.ccwrite[1] = 1'b1; bus.daddr[1] = 32'h500;
    bus.iREN[0] = 1'b1; bus.iaddr[0] = 32'h600;
    tick(); #2; chk("d_owner_c1", bus.ccwait, 4'b1101);
    tick(); bus.cctrans[0] = 1'b1; bus.dstore[0] = 32'hD0; #2; chk("d_snp2_ccwait", bus.ccwait, 4'b1101);
    tick(); #2;
    chk("d_w0_dload", bus.dload[1], 32'hD0);
    chk("d_w0_dwait", bus.dwait, 4'b1100);
    chk("d_w0_ram", {bus.ramREN, bus.ramWEN}, 0);
    tick(); bus.dstore[0] = 32'hD1; #2; chk("d_gap_dwait", bus.dwait, 4'hF);
    tick(); #2;
    chk("d_w1_dload", bus.dload[1], 32'hD1);
    chk("d_w1_dwait", bus.dwait, 4'b1100);
    chk("d_w1_ram", {bus.ramREN, bus.ramWEN}, 0);
    bus.dREN[1] = 1'b0; bus.cctrans = '0; bus.ccwrite = '0;
    tick(); #2;
    chk("d_ccinv", bus.ccinv, 4'b1101);
    chk("d_inv1_dwait", bus.dwait, 4'hF);
    tick(); #2;
    chk("d_inv2_ccinv", bus.ccinv, 0);
    chk("d_inv2_dwait", bus.dwait, 4'b1101);
    tick();
    tick(); bus.ramstate = ACCESS; bus.ramload = 32'h77; bus.iREN = '0; #2;
    chk("d_ird_addr", bus.ramaddr, 32'h600);
    chk("d_ird_iload", bus.iload[0], 32'h77);
    chk("d_ird_iwait", bus.iwait, 4'b1110);
    tick(); bus.ramstate = FREE;
    // core0 writeback, RAM completes each word after three busy cycles
    bus.dWEN[0] = 1'b1; bus.cctrans[0] = 1'b1;
    tick();
    wb_word(32'hDEAD0000, 32'h400);
    #2; chk("e_gap_wen", bus.ramWEN, 0);
    tick();
    wb_word(32'hDEAD0004, 32'h404);
    #2;
    chk("e_idle_wen", bus.ramWEN, 0);
    chk("e_idle_dwait", bus.dwait, 4'hF);
    chk("e_idle_ccwait", bus.ccwait, 0);
    // reset while the second load word is outstanding
    bus.dREN[2] = 1'b1; bus.cctrans[2] = 1'b1; bus.daddr[2] = 32'h700;
    tick(); tick();
    tick(); bus.ramstate = ACCESS; bus.dREN = '0; bus.cctrans = '0;
    tick(); bus.ramstate = FREE;
    tick(); bus.ramstate = BUSY; #2;
    chk("f_ld1_ren", bus.ramREN, 1);
    rst = 1'b1;
    tick(); rst = 1'b0; #2;
    chk("f_rst_ren", bus.ramREN, 0);
    chk("f_rst_dwait", bus.dwait, 4'hF);
    chk("f_rst_iwait", bus.iwait, 4'hF);
    chk("f_rst_ccwait", bus.ccwait, 0);
    chk("f_rst_c2c", bus.stat_c2c, 0);
    chk("f_rst_memrd", bus.stat_memrd, 0);
    chk("f_rst_memwr", bus.stat_memwr, 0);
    chk("f_rst_inv", bus.stat_inv, 0);
    tick(); #2;
    chk("f_idle_ren", bus.ramREN, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
